// File: rtl/cpu_pkg.sv
// Shared definitions for the load/store memory controller.
//   SIZE_* : request size encodings (11 behaves as a word)
//   mem_state_t : controller states
//   IO_BASE : first IO-mapped byte address
//   size_bytes() : byte count for a size encoding
package cpu_pkg;
  localparam logic [1:0]  SIZE_B  = 2'b00;
  localparam logic [1:0]  SIZE_H  = 2'b01;
  localparam logic [1:0]  SIZE_W  = 2'b10;
  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  typedef enum logic [1:0] {IDLE, READ, IO_WAIT, WRITE} mem_state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/lsb_load_extend.sv
// Load result assembly and zero/sign extension (combinational).
//   lo   : bytes 0..2 already captured from RAM
//   last : final byte of the access, taken straight from the RAM port
//   size : access size encoding
//   sgn  : sign-extend from bit 8N-1
//   data : extended 32-bit load result
module lsb_load_extend
  import cpu_pkg::*;
(
  input  logic [2:0][7:0] lo,
  input  logic [7:0]      last,
  input  logic [1:0]      size,
  input  logic            sgn,
  output logic [31:0]     data
);
  // The last byte is always the most significant one, so it alone
  // decides the extension bit.
  always_comb begin
    data = '0;
    case (size)
      SIZE_B:  data = {{24{sgn & last[7]}}, last};
      SIZE_H:  data = {{16{sgn & last[7]}}, last, lo[0]};
      default: data = {last, lo[2], lo[1], lo[0]};
    endcase
  end
endmodule

// File: rtl/lsb_mem_ctrl.sv
// Memory-side responder for the store/load buffer. Serialises one load or
// store at a time onto a byte-wide RAM port (read data one cycle after its
// address) and returns a one-cycle completion pulse with the ROB tag.
// Ports:
//   clk_in, rst_n_in       clock, async active-low reset
//   rdy_in                 global ready; low freezes every register
//   clear_in               ROB flush: aborts loads, blocks accept
//   req_*                  SLB request (valid/ready handshake)
//   resp_*                 completion pulse, tag, load data (0 for stores)
//   mem_din/dout/a/wr      byte-wide RAM port
//   io_buffer_full         UART full flag
// Build option: define LSB_IO_STALL_EN to hold IO-range stores in IO_WAIT
// while io_buffer_full is high; otherwise io_buffer_full is ignored.
module lsb_mem_ctrl
  import cpu_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          TAG_W   = 4,
  parameter logic [31:0] IO_BASE = cpu_pkg::IO_BASE
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic              req_store_in,
  input  logic [1:0]        req_size_in,
  input  logic              req_signed_in,
  input  logic [ADDR_W-1:0] req_addr_in,
  input  logic [31:0]       req_wdata_in,
  input  logic [TAG_W-1:0]  req_tag_in,
  output logic              resp_valid_out,
  output logic [TAG_W-1:0]  resp_tag_out,
  output logic [31:0]       resp_data_out,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
  mem_state_t        state;
  logic [2:0]        cnt;
  logic [2:0]        nbytes;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic              sgn;
  logic [3:0][7:0]   wdata;
  logic [TAG_W-1:0]  tag;
  logic [2:0][7:0]   rbyte;
  logic [31:0]       ld_data;
  logic              accept;

  assign req_ready_out = (state == IDLE);
  assign accept        = req_valid_in & req_ready_out & rdy_in & ~clear_in;
  assign nbytes        = size_bytes(size);

`ifdef LSB_IO_STALL_EN
  logic req_io;
  assign req_io = (req_addr_in[17:16] == IO_BASE[17:16]);
`else
  logic unused_io;
  assign unused_io = ^{io_buffer_full, IO_BASE};
`endif

  lsb_load_extend u_ext (
    .lo   (rbyte),
    .last (mem_din),
    .size (size),
    .sgn  (sgn),
    .data (ld_data)
  );

  // READ: cnt counts edges since accept. Address index cnt is on mem_a,
  // byte cnt-1 is on mem_din; at cnt==N the final byte feeds the
  // extender directly and the response is registered.
  // WRITE: cnt is the byte currently on the write port.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      cnt            <= '0;
      addr           <= '0;
      size           <= SIZE_B;
      sgn            <= 1'b0;
      wdata          <= '0;
      tag            <= '0;
      rbyte          <= '0;
      resp_valid_out <= 1'b0;
      resp_tag_out   <= '0;
      resp_data_out  <= '0;
      mem_a          <= '0;
      mem_dout       <= '0;
      mem_wr         <= 1'b0;
    end else if (rdy_in) begin
      resp_valid_out <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          addr  <= req_addr_in;
          size  <= req_size_in;
          sgn   <= req_signed_in;
          wdata <= req_wdata_in;
          tag   <= req_tag_in;
          cnt   <= '0;
          mem_a <= req_addr_in;
          if (!req_store_in) state <= READ;
`ifdef LSB_IO_STALL_EN
          else if (req_io && io_buffer_full) state <= IO_WAIT;
`endif
          else begin
            state    <= WRITE;
            mem_wr   <= 1'b1;
            mem_dout <= req_wdata_in[7:0];
          end
        end
        READ: begin
          if (clear_in) begin
            state <= IDLE;  // flush: drop the in-flight byte, no response
          end else if (cnt == nbytes) begin
            state          <= IDLE;
            resp_valid_out <= 1'b1;
            resp_tag_out   <= tag;
            resp_data_out  <= ld_data;
          end else begin
            if (cnt != 3'd0) rbyte[2'(cnt - 3'd1)] <= mem_din;
            cnt <= cnt + 3'd1;
            if (cnt + 3'd1 != nbytes) mem_a <= addr + ADDR_W'(cnt + 3'd1);
          end
        end
`ifdef LSB_IO_STALL_EN
        IO_WAIT: if (!io_buffer_full) begin
          state    <= WRITE;
          mem_wr   <= 1'b1;
          mem_a    <= addr;
          mem_dout <= wdata[0];
        end
`endif
        WRITE: begin
          // Stores are already committed, so clear_in is not looked at.
          if (cnt == nbytes - 3'd1) begin
            state          <= IDLE;
            mem_wr         <= 1'b0;
            resp_valid_out <= 1'b1;
            resp_tag_out   <= tag;
            resp_data_out  <= '0;
          end else begin
            cnt      <= cnt + 3'd1;
            mem_a    <= addr + ADDR_W'(cnt + 3'd1);
            mem_dout <= wdata[2'(cnt + 3'd1)];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsb_mem_ctrl.sv
// Bench for lsb_mem_ctrl: byte RAM model, transaction-level reference
// model, per-cycle compare, directed literal cases, then random traffic.
module tb_lsb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n_in = 1'b1;
  logic        rdy_in = 1'b1, clear_in = 1'b0, req_valid_in = 1'b0;
  logic        req_store_in = 1'b0, req_signed_in = 1'b0;
  logic [1:0]  req_size_in = 2'b00;
  logic [31:0] req_addr_in = '0, req_wdata_in = '0;
  logic [3:0]  req_tag_in = '0;
  logic        req_ready_out, resp_valid_out, mem_wr;
  logic [3:0]  resp_tag_out;
  logic [31:0] resp_data_out, mem_a;
  logic [7:0]  mem_din = '0, mem_dout;
  logic        io_buffer_full = 1'b0;

  always #5 clk = ~clk;

  lsb_mem_ctrl #(.ADDR_W(32), .TAG_W(4)) dut (
    .clk_in(clk), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_store_in(req_store_in), .req_size_in(req_size_in),
    .req_signed_in(req_signed_in), .req_addr_in(req_addr_in),
    .req_wdata_in(req_wdata_in), .req_tag_in(req_tag_in),
    .resp_valid_out(resp_valid_out), .resp_tag_out(resp_tag_out),
    .resp_data_out(resp_data_out), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  // RAM: 1 KiB aliased, synchronous read, frozen by rdy_in
  logic [7:0] ram [0:1023];
  always @(posedge clk) if (rdy_in) begin
    if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    mem_din <= ram[mem_a[9:0]];
  end

  int checks = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nb(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] a, input int n, input bit sg);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v |= 32'(ram[10'(a + 32'(k))]) << (8 * k);
    if (sg && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  // Reference model: one transaction in flight, m_t counts live edges
  bit          m_busy = 0, m_store = 0, m_wait = 0, m_resp = 0;
  int          m_n = 1, m_t = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_data = '0, r_data = '0;
  logic [3:0]  m_tag = '0, r_tag = '0;

  initial forever begin
    @(posedge clk or negedge rst_n_in);
    if (!rst_n_in) begin
      m_busy = 0; m_resp = 0;
    end else if (rdy_in) begin
      m_resp = 0;
      if (!m_busy) begin
        if (req_valid_in && !clear_in) begin
          m_busy = 1; m_store = req_store_in; m_n = nb(req_size_in);
          m_addr = req_addr_in; m_wdata = req_wdata_in; m_tag = req_tag_in; m_t = 0;
          m_wait = 0;
`ifdef LSB_IO_STALL_EN
          m_wait = req_store_in && (req_addr_in[17:16] == 2'b11) && io_buffer_full;
`endif
          if (!req_store_in) m_data = load_val(req_addr_in, m_n, req_signed_in);
        end
      end else if (!m_store) begin
        if (clear_in) m_busy = 0;
        else if (m_t == m_n) begin
          m_busy = 0; m_resp = 1; r_tag = m_tag; r_data = m_data;
        end else m_t++;
      end else if (m_wait) begin
        if (!io_buffer_full) m_wait = 0;
      end else begin
        m_t++;
        if (m_t == m_n) begin m_busy = 0; m_resp = 1; r_tag = m_tag; r_data = '0; end
      end
    end
  end

  // Per-cycle compare against the model
  initial forever begin
    logic [31:0] sh;
    @(negedge clk);
    if (rst_n_in) begin
      chk("ready", req_ready_out, !m_busy);
      chk("resp_valid", resp_valid_out, m_resp);
      if (m_resp) begin
        chk("resp_tag", resp_tag_out, r_tag);
        chk("resp_data", resp_data_out, r_data);
      end
      if (m_busy && !m_store && m_t < m_n) begin
        chk("rd_addr", mem_a, m_addr + 32'(m_t));
        chk("rd_wr", mem_wr, 0);
      end else if (m_busy && m_store && !m_wait) begin
        sh = m_wdata >> (8 * m_t);
        chk("wr_en", mem_wr, 1);
        chk("wr_addr", mem_a, m_addr + 32'(m_t));
        chk("wr_data", mem_dout, sh[7:0]);
      end else chk("idle_wr", mem_wr, 0);
    end
  end

  // Directed helpers: logs indexed by cycle after the accept edge
  logic [31:0] la [0:15];
  logic        lw [0:15], lr [0:15];
  logic [7:0]  ld [0:15];

  task automatic issue(input bit st, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] tg);
    rdy_in = 1; clear_in = 0;
    req_valid_in = 1; req_store_in = st; req_size_in = sz; req_signed_in = sg;
    req_addr_in = a; req_wdata_in = wd; req_tag_in = tg;
    @(negedge clk);
    req_valid_in = 0;
  endtask

  task automatic run(input int stall_at, input int clear_at, input int io_until,
                     output bit found, output int cyc, output logic [31:0] d);
    found = 0; cyc = -1; d = '0;
    for (int c = 0; c < 12; c++) begin
      la[c] = mem_a; lw[c] = mem_wr; ld[c] = mem_dout; lr[c] = req_ready_out;
      if (resp_valid_out && !found) begin found = 1; cyc = c; d = resp_data_out; end
      rdy_in = !(c >= stall_at && c < stall_at + 2);
      clear_in = (c == clear_at);
      io_buffer_full = (c < io_until);
      @(negedge clk);
    end
    rdy_in = 1; clear_in = 0; io_buffer_full = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  bit          f;
  int          cy;
  logic [31:0] dd;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
    ram[10'h007] = 8'h80; ram[10'h009] = 8'h34; ram[10'h00A] = 8'h92;
    ram[10'h3FE] = 8'hAA; ram[10'h3FF] = 8'hBB; ram[10'h000] = 8'hCC; ram[10'h001] = 8'hDD;

    #2 rst_n_in = 0;
    #1;
    chk("rst_resp_valid", resp_valid_out, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_dout", mem_dout, 0);
    chk("rst_resp_data", resp_data_out, 0);
    chk("rst_ready", req_ready_out, 1);
    @(negedge clk); @(negedge clk);
    rst_n_in = 1;
    idle(2);

    // load word @0x100
    issue(0, 2'b10, 0, 32'h100, 0, 4'h3);
    run(-10, -1, 0, f, cy, dd);
    chk("t1_found", f, 1); chk("t1_lat", cy, 5); chk("t1_data", dd, 32'h44332211);
    chk("t1_a0", la[0], 32'h100); chk("t1_a3", la[3], 32'h103);
    idle(2);

    // signed byte @7, unsigned half @9
    issue(0, 2'b00, 1, 32'h7, 0, 4'h4);
    run(-10, -1, 0, f, cy, dd);
    chk("t2_sb_lat", cy, 2); chk("t2_sb_data", dd, 32'hFFFFFF80);
    idle(2);
    issue(0, 2'b01, 0, 32'h9, 0, 4'h5);
    run(-10, -1, 0, f, cy, dd);
    chk("t2_uh_lat", cy, 3); chk("t2_uh_data", dd, 32'h00009234);
    idle(2);

    // rdy_in low during cycles 1 and 2 of a word load
    issue(0, 2'b10, 0, 32'h100, 0, 4'h6);
    run(1, -1, 0, f, cy, dd);
    chk("t6_lat", cy, 7); chk("t6_data", dd, 32'h44332211);
    chk("t6_hold", la[3], 32'h101); chk("t6_a5", la[5], 32'h103);
    idle(2);

    // address wrap
    issue(0, 2'b10, 0, 32'hFFFFFFFE, 0, 4'h7);
    run(-10, -1, 0, f, cy, dd);
    chk("wrap_a1", la[1], 32'hFFFFFFFF); chk("wrap_a2", la[2], 32'h0);
    chk("wrap_data", dd, 32'hDDCCBBAA);
    idle(2);

    // store half 0xABCD @0x201
    issue(1, 2'b01, 0, 32'h201, 32'h1234ABCD, 4'h8);
    run(-10, -1, 0, f, cy, dd);
    chk("t3_lat", cy, 2); chk("t3_data", dd, 0);
    chk("t3_w0", {lw[0], la[0][11:0], ld[0]}, {1'b1, 12'h201, 8'hCD});
    chk("t3_w1", {lw[1], la[1][11:0], ld[1]}, {1'b1, 12'h202, 8'hAB});
    chk("t3_w2", lw[2], 0);
    idle(2);

    // clear during cycle 2 of a word load
    issue(0, 2'b10, 0, 32'h100, 0, 4'h9);
    run(-10, 2, 0, f, cy, dd);
    chk("t4_noresp", f, 0); chk("t4_ready", lr[3], 1);
    idle(2);
    // clear during a store: still completes
    issue(1, 2'b10, 0, 32'h300, 32'hDEADBEEF, 4'hA);
    run(-10, 1, 0, f, cy, dd);
    chk("t4s_lat", cy, 4);
    chk("t4s_ram", {ram[10'h303], ram[10'h300]}, 16'hDEEF);
    idle(2);

    // IO store while the UART buffer is full
    io_buffer_full = 1;
    issue(1, 2'b00, 0, 32'h30000, 32'h41, 4'hB);
    run(-10, -1, 2, f, cy, dd);
`ifdef LSB_IO_STALL_EN
    chk("t5_stall", lw[1], 0); chk("t5_w", {lw[3], ld[3]}, {1'b1, 8'h41}); chk("t5_lat", cy, 4);
`else
    chk("t5_w", {lw[0], ld[0]}, {1'b1, 8'h41}); chk("t5_a", la[0], 32'h30000); chk("t5_lat", cy, 1);
`endif
    idle(2);

    // async reset in the middle of a store
    issue(1, 2'b10, 0, 32'h340, 32'h12345678, 4'hC);
    @(negedge clk);
    #2 rst_n_in = 0;
    #1;
    chk("mr_wr", mem_wr, 0); chk("mr_a", mem_a, 0); chk("mr_dout", mem_dout, 0);
    chk("mr_resp", resp_valid_out, 0); chk("mr_ready", req_ready_out, 1);
    @(negedge clk);
    rst_n_in = 1;
    idle(2);

    // random traffic
    repeat (3000) begin
      rdy_in         = ($urandom_range(0, 7) != 0);
      clear_in       = ($urandom_range(0, 15) == 0);
      io_buffer_full = 1'($urandom_range(0, 1));
      req_valid_in   = 1'($urandom_range(0, 1));
      req_store_in   = 1'($urandom_range(0, 1));
      req_size_in    = 2'($urandom_range(0, 3));
      req_signed_in  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       req_addr_in = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        1:       req_addr_in = 32'h30000 + 32'($urandom_range(0, 7));
        default: req_addr_in = 32'($urandom_range(0, 1023));
      endcase
      req_wdata_in = $urandom;
      req_tag_in   = 4'($urandom);
      @(negedge clk);
    end
    req_valid_in = 0; rdy_in = 1; clear_in = 0; io_buffer_full = 0;
    idle(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
